// File: rtl/demux_stream_nx.sv
// ---------------------------------------------------------------------------
// demux_stream_nx
//   Registered 1-to-CH stream demultiplexer. An input word goes to the channel
//   selected by sel, or to every channel when bcast=1. Each channel keeps one
//   word in an output slot, and the block applies backpressure upstream.
//   Words addressed to a channel index >= CH are accepted and discarded.
//   A saturating counter records how many words were discarded.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. valid must not depend on ready. Data must stay stable while
//   valid=1 and ready=0.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   en         in   1          0 = stop accepting input; slots keep draining
//   in_valid   in   1          input word valid
//   in_ready   out  1          block can accept input this cycle
//   i          in   BIT        input word
//   sel        in   SEL_BIT    destination channel index
//   bcast      in   1          1 = write the word to every channel
//   out_valid  out  CH         per-channel output valid (slot full)
//   out_ready  in   CH         per-channel consumer ready
//   d          out  CH*BIT     channel k data on d[k*BIT +: BIT]; zero when empty
//   drop_cnt   out  CNT_BIT    saturating count of words dropped for sel >= CH
// ---------------------------------------------------------------------------
module demux_stream_nx #(
    parameter int BIT     = 3,
    parameter int CH      = 4,
    parameter int SEL_BIT = 2,
    parameter int CNT_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT-1:0]       i,
    input  logic [SEL_BIT-1:0]   sel,
    input  logic                 bcast,
    output logic [CH-1:0]        out_valid,
    input  logic [CH-1:0]        out_ready,
    output logic [CH*BIT-1:0]    d,
    output logic [CNT_BIT-1:0]   drop_cnt
);

    logic [BIT-1:0] slot_q [CH];
    logic [CH-1:0]  full_q;
    logic [CH-1:0]  avail;
    logic [CH-1:0]  sel_hit;
    logic [CH-1:0]  load;
    logic           sel_ok;
    logic           accept;
    logic           drop;

    // One-hot decode of sel. An index >= CH matches no channel, so sel_ok
    // doubles as the in-range test without a width-sensitive comparison.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < CH; k++) begin
            sel_hit[k] = (32'(sel) == k);
        end
    end

    assign sel_ok = |sel_hit;

    // A slot that drains this cycle can take a new word in the same edge.
    assign avail = ~full_q | out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n && en) begin
            if (bcast) begin
                in_ready = &avail;
            end else if (sel_ok) begin
                in_ready = |(avail & sel_hit);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~bcast & ~sel_ok;

    always_comb begin
        load = '0;
        if (accept) begin
            load = bcast ? {CH{1'b1}} : sel_hit;
        end
    end

    // The slot register is cleared when it empties, so d is zero on an idle
    // lane without any masking logic between the register and the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < CH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (load[k]) begin
                    slot_q[k] <= i;
                    full_q[k] <= 1'b1;
                end else if (full_q[k] && out_ready[k]) begin
                    slot_q[k] <= '0;
                    full_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_BIT{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_valid = full_q;

    always_comb begin
        d = '0;
        for (int k = 0; k < CH; k++) begin
            d[k*BIT +: BIT] = slot_q[k];
        end
    end

endmodule
